// File: rtl/data_mem_responder_if.sv
// Load/store bus between the RV32I core's data-memory port and data_mem_responder.
// Request channel : DMEM_Req_Valid_In / DMEM_Req_Ready_Out, with write flag, byte address,
//                   byte enables and lane-aligned store data.
// Response channel: DMEM_Rsp_Valid_Out / DMEM_Rsp_Ready_In with the full load word.
// Status          : DMEM_Wr_Done_Out (store committed pulse), DMEM_Err_Out (address out of range).
// Modports: master = core side, slave = responder side.
interface data_mem_responder_if #(
   parameter int unsigned DATAWIDTH = 32
);

   logic                     DMEM_Req_Valid_In;
   logic                     DMEM_Req_Ready_Out;
   logic                     DMEM_Req_Write_In;
   logic [DATAWIDTH-1:0]     DMEM_Addr_InBUS;
   logic [DATAWIDTH/8-1:0]   DMEM_Byteenable_InBUS;
   logic [DATAWIDTH-1:0]     DMEM_Writedata_InBUS;
   logic                     DMEM_Rsp_Valid_Out;
   logic                     DMEM_Rsp_Ready_In;
   logic [DATAWIDTH-1:0]     DMEM_Readdata_OutBUS;
   logic                     DMEM_Wr_Done_Out;
   logic                     DMEM_Err_Out;

   modport master (
      output DMEM_Req_Valid_In,
      input  DMEM_Req_Ready_Out,
      output DMEM_Req_Write_In,
      output DMEM_Addr_InBUS,
      output DMEM_Byteenable_InBUS,
      output DMEM_Writedata_InBUS,
      input  DMEM_Rsp_Valid_Out,
      output DMEM_Rsp_Ready_In,
      input  DMEM_Readdata_OutBUS,
      input  DMEM_Wr_Done_Out,
      input  DMEM_Err_Out
   );

   modport slave (
      input  DMEM_Req_Valid_In,
      output DMEM_Req_Ready_Out,
      input  DMEM_Req_Write_In,
      input  DMEM_Addr_InBUS,
      input  DMEM_Byteenable_InBUS,
      input  DMEM_Writedata_InBUS,
      output DMEM_Rsp_Valid_Out,
      input  DMEM_Rsp_Ready_In,
      output DMEM_Readdata_OutBUS,
      output DMEM_Wr_Done_Out,
      output DMEM_Err_Out
   );

endinterface

// File: rtl/data_mem_responder.sv
// Data-memory target for the RV32I multi-cycle core. Accepts one load/store at a time, inserts
// WAIT_STATES programmable wait cycles, then performs a single RAM access. Stores are byte-enable
// writes acknowledged by a one-cycle DMEM_Wr_Done_Out pulse; loads return the full word through a
// valid/ready response handshake. Out-of-range addresses raise DMEM_Err_Out instead of touching RAM.
// Ports:
//   DMEM_Clk_In    clock, rising edge
//   DMEM_Reset_In  asynchronous active-high reset (RAM contents are kept)
//   dmemBus        data_mem_responder_if slave modport (request, response and status signals)
module data_mem_responder #(
   parameter int unsigned DATAWIDTH   = 32,
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned WAIT_STATES = 1
) (
   input logic                 DMEM_Clk_In,
   input logic                 DMEM_Reset_In,
   data_mem_responder_if.slave dmemBus
);

   localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
   localparam int unsigned BeWidth = DATAWIDTH / 8;

   typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

   state_e                 stateQ, stateD;
   logic [3:0]             waitCntQ, waitCntD;

   logic                   reqWriteQ;
   logic [DATAWIDTH-1:0]   addrQ;
   logic [BeWidth-1:0]     beQ;
   logic [DATAWIDTH-1:0]   wdataQ;

   logic [DATAWIDTH-1:0]   readDataQ;
   logic                   wrDoneQ;
   logic                   errQ;

   logic                   reqReady;
   logic                   rspValid;
   logic                   accept;

   logic [DATAWIDTH-1:0]   addrOffset;
   logic [DATAWIDTH-1:0]   wordIdx;
   logic [DEPTH_LOG2-1:0]  ramIdx;
   logic                   inRange;
   logic                   memWrite;

   logic [DATAWIDTH-1:0]   mem [Depth];

   // Address decode on the latched request. The base check is separate from the index check so an
   // address below BASE_ADDR can never wrap around into the RAM window.
   assign addrOffset = addrQ - DATAWIDTH'(BASE_ADDR);
   assign wordIdx    = addrOffset >> 2;
   assign inRange    = (addrQ >= DATAWIDTH'(BASE_ADDR)) && (wordIdx < DATAWIDTH'(Depth));
   assign ramIdx     = wordIdx[DEPTH_LOG2-1:0];
   assign memWrite   = (stateQ == StAccess) && reqWriteQ && inRange;

   // Next-state and handshake outputs
   always_comb begin
      stateD   = stateQ;
      waitCntD = waitCntQ;
      reqReady = 1'b0;
      rspValid = 1'b0;
      accept   = 1'b0;
      unique case (stateQ)
         StIdle: begin
            reqReady = 1'b1;
            if (dmemBus.DMEM_Req_Valid_In) begin
               accept = 1'b1;
               if (WAIT_STATES > 0) begin
                  stateD   = StWait;
                  waitCntD = 4'(WAIT_STATES - 1);
               end else begin
                  stateD = StAccess;
               end
            end
         end
         StWait: begin
            if (waitCntQ == 4'd0) begin
               stateD = StAccess;
            end else begin
               waitCntD = waitCntQ - 4'd1;
            end
         end
         StAccess: begin
            stateD = reqWriteQ ? StIdle : StResp;
         end
         StResp: begin
            rspValid = 1'b1;
            if (dmemBus.DMEM_Rsp_Ready_In) begin
               stateD = StIdle;
            end
         end
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   always_ff @(posedge DMEM_Clk_In or posedge DMEM_Reset_In) begin
      if (DMEM_Reset_In) begin
         stateQ    <= StIdle;
         waitCntQ  <= 4'd0;
         reqWriteQ <= 1'b0;
         addrQ     <= '0;
         beQ       <= '0;
         wdataQ    <= '0;
         readDataQ <= '0;
         wrDoneQ   <= 1'b0;
         errQ      <= 1'b0;
      end else begin
         stateQ   <= stateD;
         waitCntQ <= waitCntD;
         if (accept) begin
            reqWriteQ <= dmemBus.DMEM_Req_Write_In;
            addrQ     <= dmemBus.DMEM_Addr_InBUS;
            beQ       <= dmemBus.DMEM_Byteenable_InBUS;
            wdataQ    <= dmemBus.DMEM_Writedata_InBUS;
         end
         // Store acknowledge lands in the cycle after the commit edge, alongside Req_Ready.
         wrDoneQ <= (stateQ == StAccess) && reqWriteQ;
         if (stateQ == StAccess) begin
            errQ <= ~inRange;
            if (!reqWriteQ) begin
               readDataQ <= inRange ? mem[ramIdx] : '0;
            end
         end
      end
   end

   // RAM array: intentionally not reset. Writes are gated by stateQ, which the async reset clears,
   // so a store caught mid-flight by reset never commits.
   always_ff @(posedge DMEM_Clk_In) begin
      if (memWrite) begin
         for (int unsigned i = 0; i < BeWidth; i++) begin
            if (beQ[i]) begin
               mem[ramIdx][8*i +: 8] <= wdataQ[8*i +: 8];
            end
         end
      end
   end

   assign dmemBus.DMEM_Req_Ready_Out   = reqReady;
   assign dmemBus.DMEM_Rsp_Valid_Out   = rspValid;
   assign dmemBus.DMEM_Readdata_OutBUS = readDataQ;
   assign dmemBus.DMEM_Wr_Done_Out     = wrDoneQ;
   // errQ outlives its transaction; only expose it while a completion is being signalled.
   assign dmemBus.DMEM_Err_Out         = errQ & (rspValid | wrDoneQ);

endmodule
